// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: prioritised stall/flush sequencer for a 5-stage pipeline
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_rs/id_rt (+_vld) ID-stage source specifiers and their read flags
//   ex_memrd, ex_rd     EX-stage load flag and destination specifier
//   br_taken            branch/jump resolved taken in EX
//   mem_req, mem_done   data-memory access in MEM and its completion
//   halt_in             HALT instruction in WB
//   *_en, *_flush       PC / pipeline-latch write enables and NOP inserts
//   halted              sticky halt indication
//   stall_cnt           stall cycle counter (PIPE_STALL_CNT_EN), else 0
module pipe_stall_ctrl #(
    parameter int REG_W     = 5,
    parameter int CNT_W     = 16,
    parameter bit R0_EXEMPT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic             id_rs_vld,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rt_vld,
    input  logic             ex_memrd,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_done,
    input  logic             halt_in,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, MEMWAIT, HALT} state_t;

    state_t state, state_nxt;
    logic   lu, frz, hold;

    assign lu = ex_memrd && ((id_rs_vld && id_rs == ex_rd) || (id_rt_vld && id_rt == ex_rd))
                && (!R0_EXEMPT || ex_rd != '0);
    assign frz = mem_req && !mem_done;
    // once waiting, only mem_done releases the freeze
    assign hold = (state == MEMWAIT) ? !mem_done : frz;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= RUN;
        else     state <= state_nxt;

    always_comb begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        {ifid_flush, idex_flush, memwb_flush} = 3'b000;
        state_nxt = state;
        if (rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            state_nxt = RUN;
        end else if (state == HALT || halt_in) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            state_nxt = HALT;
        end else if (hold) begin
            // freeze everything up to EX/MEM, drain a bubble into WB
            {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
            memwb_flush = 1'b1;
            state_nxt = MEMWAIT;
        end else begin
            state_nxt = RUN;
            if (br_taken) begin
                {ifid_flush, idex_flush} = 2'b11;
            end else if (lu) begin
                {pc_en, ifid_en} = 2'b00;
                idex_flush = 1'b1;
            end
        end
    end

    assign halted = (state == HALT);

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (!pc_en && state != HALT && cnt != '1) cnt <= cnt + 1'b1;

    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: scoreboard bench, two DUTs (R0 checked / R0 exempt, narrow counter)
module tb_pipe_stall_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
    logic id_rs_vld = 0, id_rt_vld = 0, ex_memrd = 0, br_taken = 0;
    logic mem_req = 0, mem_done = 0, halt_in = 0;
    logic [1:0] pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic [1:0] ifid_flush, idex_flush, memwb_flush, halted;
    logic [15:0] stall_cnt0;
    logic [2:0]  stall_cnt1;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.REG_W(5), .CNT_W(16), .R0_EXEMPT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt),
        .id_rt_vld(id_rt_vld), .ex_memrd(ex_memrd), .ex_rd(ex_rd), .br_taken(br_taken),
        .mem_req(mem_req), .mem_done(mem_done), .halt_in(halt_in),
        .pc_en(pc_en[0]), .ifid_en(ifid_en[0]), .idex_en(idex_en[0]), .exmem_en(exmem_en[0]),
        .memwb_en(memwb_en[0]), .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]),
        .memwb_flush(memwb_flush[0]), .halted(halted[0]), .stall_cnt(stall_cnt0));

    pipe_stall_ctrl #(.REG_W(5), .CNT_W(3), .R0_EXEMPT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_vld(id_rs_vld), .id_rt(id_rt),
        .id_rt_vld(id_rt_vld), .ex_memrd(ex_memrd), .ex_rd(ex_rd), .br_taken(br_taken),
        .mem_req(mem_req), .mem_done(mem_done), .halt_in(halt_in),
        .pc_en(pc_en[1]), .ifid_en(ifid_en[1]), .idex_en(idex_en[1]), .exmem_en(exmem_en[1]),
        .memwb_en(memwb_en[1]), .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]),
        .memwb_flush(memwb_flush[1]), .halted(halted[1]), .stall_cnt(stall_cnt1));

    // expected {halted, pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, memwb_fl}
    typedef struct {
        logic [8:0] o0, o1;
        int         c0, c1;
        int         id;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0, failures = 0, cycle = 0;
    bit   m_halt[2], m_wait[2];
    int   m_cnt[2];
    int   cnt_max[2] = '{65535, 7};

    task automatic drive(input logic [4:0] rs, input logic rsv, input logic [4:0] rt,
                         input logic rtv, input logic memrd, input logic [4:0] rd,
                         input logic br, input logic req, input logic done,
                         input logic halt, input logic r);
        logic [8:0] o[2];
        bit nh[2], nw[2];
        bit hit;
        exp_t e;
        {id_rs, id_rs_vld, id_rt, id_rt_vld, ex_memrd, ex_rd} = {rs, rsv, rt, rtv, memrd, rd};
        {br_taken, mem_req, mem_done, halt_in, rst} = {br, req, done, halt, r};
        for (int k = 0; k < 2; k++) begin
            hit = memrd && ((rsv && rs == rd) || (rtv && rt == rd)) && !(k == 1 && rd == 0);
            nh[k] = 0;
            nw[k] = 0;
            if (r) o[k] = '0;
            else if (m_halt[k] || halt) begin
                o[k] = {m_halt[k], 8'b0};
                nh[k] = 1;
            end else if (m_wait[k] ? !done : (req && !done)) begin
                o[k] = 9'b0_00001001;
                nw[k] = 1;
            end else if (br) o[k] = 9'b0_11111110;
            else if (hit)    o[k] = 9'b0_00111010;
            else             o[k] = 9'b0_11111000;
        end
        e.o0 = o[0];
        e.o1 = o[1];
        e.c0 = r ? 0 : m_cnt[0];
        e.c1 = r ? 0 : m_cnt[1];
        e.id = cycle;
        sbq.push_back(e);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
`ifdef PIPE_STALL_CNT_EN
            if (r) m_cnt[k] = 0;
            else if (!o[k][7] && !m_halt[k] && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
`else
            m_cnt[k] = 0;
`endif
            m_halt[k] = nh[k];
            m_wait[k] = nw[k];
        end
        cycle++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [8:0] a0, a1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            a0 = {halted[0], pc_en[0], ifid_en[0], idex_en[0], exmem_en[0], memwb_en[0],
                  ifid_flush[0], idex_flush[0], memwb_flush[0]};
            a1 = {halted[1], pc_en[1], ifid_en[1], idex_en[1], exmem_en[1], memwb_en[1],
                  ifid_flush[1], idex_flush[1], memwb_flush[1]};
            checks += 4;
            if (a0 !== e.o0) begin
                failures++;
                $display("FAIL ctl0 cyc=%0d got=%b exp=%b", e.id, a0, e.o0);
            end
            if (a1 !== e.o1) begin
                failures++;
                $display("FAIL ctl1 cyc=%0d got=%b exp=%b", e.id, a1, e.o1);
            end
            if (int'(stall_cnt0) != e.c0) begin
                failures++;
                $display("FAIL cnt0 cyc=%0d got=%0d exp=%0d", e.id, stall_cnt0, e.c0);
            end
            if (int'(stall_cnt1) != e.c1) begin
                failures++;
                $display("FAIL cnt1 cyc=%0d got=%0d exp=%0d", e.id, stall_cnt1, e.c1);
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        drive(3, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0);   // load-use on rs
        idle(1);
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);   // rt=r0 vs load to r0
        idle(1);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);   // memory release
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);   // single-cycle access
        drive(5, 1, 0, 0, 1, 5, 1, 0, 0, 0, 0);   // branch beats load-use
        drive(5, 1, 0, 0, 1, 5, 1, 1, 0, 0, 0);   // freeze beats branch
        drive(5, 1, 0, 0, 1, 5, 1, 1, 1, 0, 0);   // release with branch
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // halt
        for (int i = 0; i < 10; i++) drive(2, 1, 2, 1, 1, 2, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 12; i++) drive(1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0);  // saturate narrow cnt
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);   // reset mid-stall
        idle(1);
        for (int i = 0; i < 3000; i++)
            drive(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 199) == 0),
                  1'($urandom_range(0, 79) == 0));
        idle(1);
        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending exp=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
